// File: rtl/routing_xbar_rr_if.sv
// Handshake bundle between the crossbar and its neighbours: per-port input
// packets with ready, per-port output registers with downstream ready.
interface routing_xbar_rr_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PKT_W     = 32
);
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0][PKT_W-1:0] in_pkt;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS-1:0]            out_valid;
  logic [NUM_PORTS-1:0][PKT_W-1:0] out_pkt;
  logic [NUM_PORTS-1:0]            out_ready;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt
  );
endinterface

// File: rtl/routing_xbar_rr.sv
// NUM_PORTS x NUM_PORTS crossbar: table-routed inputs, one round-robin arbiter
// and one output register per output port, saturating contention counters.
module routing_xbar_rr #(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned PKT_W     = 32,
  parameter  int unsigned NODE_W    = 4,
  parameter  int unsigned DEST_LSB  = 0,
  parameter  int unsigned ROUTERID  = 0,
  localparam int unsigned PSEL_W    = $clog2(NUM_PORTS)
) (
  input  logic                       clock,
  input  logic                       reset,
  routing_xbar_rr_if.slave           bus,
  input  logic                       cfg_we,
  input  logic [NODE_W-1:0]          cfg_node,
  input  logic [PSEL_W-1:0]          cfg_port,
  output logic [NUM_PORTS-1:0][15:0] conflict_cnt
);
  localparam int unsigned NUM_NODES = 2 ** NODE_W;
  localparam int unsigned CNT_W     = 16;

  logic [PSEL_W-1:0]                  route_tbl [NUM_NODES];
  logic [NUM_PORTS-1:0][PSEL_W-1:0]   ptr_q;
  logic [NUM_PORTS-1:0]               out_valid_q;
  logic [NUM_PORTS-1:0][PKT_W-1:0]    out_pkt_q;
  logic [NUM_PORTS-1:0][CNT_W-1:0]    cnt_q;

  logic [NUM_PORTS-1:0][PSEL_W-1:0]   tgt;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;  // req[o][i]
  logic [NUM_PORTS-1:0]               can_accept;
  logic [NUM_PORTS-1:0]               gnt_vld;
  logic [NUM_PORTS-1:0][PSEL_W-1:0]   gnt_idx;
  logic [NUM_PORTS-1:0]               in_ready_c;

  // Route table contents after reset, chosen by router identity.
  function automatic logic [PSEL_W-1:0] reset_port(input int unsigned n);
    int unsigned p;
    if (NUM_PORTS == 4) begin
      if (ROUTERID % 2 == 0) begin
        case (n)
          0:       p = 0;
          1:       p = 2;
          2:       p = 3;
          default: p = 1;
        endcase
      end else begin
        case (n)
          3:       p = 0;
          4:       p = 1;
          5:       p = 2;
          default: p = 3;
        endcase
      end
    end else begin
      p = n % NUM_PORTS;
    end
    return PSEL_W'(p);
  endfunction

  // Each valid input requests exactly the output its destination maps to.
  always_comb begin
    tgt        = '0;
    req        = '0;
    can_accept = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      tgt[i] = route_tbl[bus.in_pkt[i][DEST_LSB +: NODE_W]];
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      can_accept[o] = !out_valid_q[o] || bus.out_ready[o];
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = bus.in_valid[i] && (tgt[i] == PSEL_W'(o));
      end
    end
  end

  // Per-output search from ptr upwards, wrapping, first requester wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    gnt_vld    = '0;
    gnt_idx    = '0;
    in_ready_c = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = 32'(ptr_q[o]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!reset && can_accept[o] && !gnt_vld[o] && req[o][PSEL_W'(idx)]) begin
          gnt_vld[o]                 = 1'b1;
          gnt_idx[o]                 = PSEL_W'(idx);
          in_ready_c[PSEL_W'(idx)]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned n = 0; n < NUM_NODES; n++) begin
        route_tbl[n] <= reset_port(n);
      end
      out_valid_q <= '0;
      out_pkt_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // Writes land at the edge, so same-cycle lookups still see the old entry.
      if (cfg_we && (32'(cfg_port) < NUM_PORTS)) begin
        route_tbl[cfg_node] <= cfg_port;
      end
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (gnt_vld[o]) begin
          out_valid_q[o] <= 1'b1;
          out_pkt_q[o]   <= bus.in_pkt[gnt_idx[o]];
          ptr_q[o]       <= (gnt_idx[o] == PSEL_W'(NUM_PORTS - 1)) ? '0
                                                                   : gnt_idx[o] + PSEL_W'(1);
        end else if (bus.out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
        if (($countones(req[o]) > 1) && (cnt_q[o] != 16'hFFFF)) begin
          cnt_q[o] <= cnt_q[o] + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pkt   = out_pkt_q;
  assign conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_routing_xbar_rr.sv
// Directed plus random checks of routing_xbar_rr against a cycle model and a
// per-output packet scoreboard.
module tb_routing_xbar_rr;
  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PKT_W     = 32;
  localparam int unsigned NODE_W    = 4;
  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned ROUTERID  = 0;
  localparam int unsigned PSEL_W    = $clog2(NUM_PORTS);
  localparam int unsigned NUM_NODES = 2 ** NODE_W;
  localparam int          NP        = NUM_PORTS;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       cfg_we;
  logic [NODE_W-1:0]          cfg_node;
  logic [PSEL_W-1:0]          cfg_port;
  logic [NUM_PORTS-1:0][15:0] conflict_cnt;

  routing_xbar_rr_if #(.NUM_PORTS(NUM_PORTS), .PKT_W(PKT_W)) bus ();

  routing_xbar_rr #(
    .NUM_PORTS(NUM_PORTS), .PKT_W(PKT_W), .NODE_W(NODE_W),
    .DEST_LSB(DEST_LSB), .ROUTERID(ROUTERID)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .cfg_we(cfg_we), .cfg_node(cfg_node), .cfg_port(cfg_port),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  int                checks = 0;
  int                errors = 0;
  int                m_tbl  [NUM_NODES];
  int                m_ptr  [NUM_PORTS];
  bit                m_ov   [NUM_PORTS];
  logic [PKT_W-1:0]  m_op   [NUM_PORTS];
  int                m_cnt  [NUM_PORTS];
  logic [PKT_W-1:0]  sb     [NUM_PORTS][$];
  logic [NUM_PORTS-1:0] last_ready;
  logic [PKT_W-1:0]  hold_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_of(input logic [PKT_W-1:0] p);
    return int'(p[DEST_LSB +: NODE_W]);
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input int node);
    logic [PKT_W-1:0] p;
    p = PKT_W'($urandom);
    p[DEST_LSB +: NODE_W] = NODE_W'(node);
    return p;
  endfunction

  // Reset table for an even router id on a 4-port router.
  task automatic model_reset();
    for (int n = 0; n < NUM_NODES; n++)
      m_tbl[n] = (n == 0) ? 0 : (n == 1) ? 2 : (n == 2) ? 3 : 1;
    for (int o = 0; o < NP; o++) begin
      m_ptr[o] = 0; m_ov[o] = 1'b0; m_op[o] = '0; m_cnt[o] = 0;
      sb[o].delete();
    end
  endtask

  task automatic drive(input int i, input bit v, input int node);
    bus.in_valid[i] = v;
    bus.in_pkt[i]   = mk_pkt(node);
  endtask

  // One clock: check in_ready before the edge, outputs after it.
  task automatic tick();
    logic [NUM_PORTS-1:0] exp_ready;
    logic [NUM_PORTS-1:0] exp_ov;
    logic [PKT_W-1:0]     gpkt [NUM_PORTS];
    int                   g [NUM_PORTS];
    int                   nreq [NUM_PORTS];
    logic [NUM_PORTS-1:0] ordy;
    bit                   r, cw;
    int                   cn, cp;
    @(negedge clock);
    r = reset; cw = cfg_we; cn = int'(cfg_node); cp = int'(cfg_port);
    ordy = bus.out_ready;
    exp_ready = '0;
    for (int o = 0; o < NP; o++) begin
      int best, bestd;
      best = -1; bestd = NP; nreq[o] = 0; gpkt[o] = '0;
      for (int i = 0; i < NP; i++) begin
        if (bus.in_valid[i] && m_tbl[dest_of(bus.in_pkt[i])] == o) begin
          int d;
          nreq[o]++;
          d = (i - m_ptr[o] + NP) % NP;
          if (d < bestd) begin best = i; bestd = d; end
        end
      end
      g[o] = (!r && (!m_ov[o] || ordy[o])) ? best : -1;
      if (g[o] >= 0) begin
        exp_ready[g[o]] = 1'b1;
        gpkt[o] = bus.in_pkt[g[o]];
      end
    end
    last_ready = bus.in_ready;
    check("in_ready", last_ready, exp_ready);
    if (!r) begin
      for (int o = 0; o < NP; o++) begin
        if (bus.out_valid[o] && ordy[o]) begin
          check($sformatf("sb_has_pkt[%0d]", o), sb[o].size() != 0, 1);
          if (sb[o].size() != 0) check($sformatf("sb_pkt[%0d]", o), bus.out_pkt[o], sb[o].pop_front());
        end
      end
      for (int i = 0; i < NP; i++)
        if (last_ready[i]) sb[m_tbl[dest_of(bus.in_pkt[i])]].push_back(bus.in_pkt[i]);
    end
    @(posedge clock);
    if (r) model_reset();
    else begin
      for (int o = 0; o < NP; o++) begin
        if (g[o] >= 0) begin
          m_ov[o] = 1'b1; m_op[o] = gpkt[o]; m_ptr[o] = (g[o] + 1) % NP;
        end else if (ordy[o]) m_ov[o] = 1'b0;
        if (nreq[o] >= 2 && m_cnt[o] < 65535) m_cnt[o]++;
      end
      if (cw && cp < NP) m_tbl[cn] = cp;
    end
    #1;
    exp_ov = '0;
    for (int o = 0; o < NP; o++) exp_ov[o] = m_ov[o];
    check("out_valid", bus.out_valid, exp_ov);
    for (int o = 0; o < NP; o++) begin
      if (m_ov[o]) check($sformatf("out_pkt[%0d]", o), bus.out_pkt[o], m_op[o]);
      check($sformatf("conflict_cnt[%0d]", o), conflict_cnt[o], 64'(m_cnt[o]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_node = '0; cfg_port = '0;
    bus.in_valid = '0; bus.in_pkt = '0; bus.out_ready = '0;
    model_reset();
    @(posedge clock); #1;
    tick();
    check("rst_in_ready", last_ready, '0);
    tick();
    check("rst_out_valid", bus.out_valid, '0);
    for (int o = 0; o < NP; o++) check($sformatf("rst_out_pkt[%0d]", o), bus.out_pkt[o], '0);
    reset = 1'b0;

    // Four inputs contend for port 0; each drops out once served.
    bus.out_ready = '1;
    for (int i = 0; i < NP; i++) drive(i, 1'b1, 0);
    tick(); check("rr_first", last_ready, 4'b0001); bus.in_valid[0] = 1'b0;
    tick(); check("rr_second", last_ready, 4'b0010); bus.in_valid[1] = 1'b0;
    tick(); check("rr_third", last_ready, 4'b0100); bus.in_valid[2] = 1'b0;
    tick(); check("rr_fourth", last_ready, 4'b1000); bus.in_valid[3] = 1'b0;
    check("rr_conflicts", conflict_cnt[0], 3);
    tick(); check("rr_drained", bus.out_valid, '0);

    // Disjoint outputs are granted together without contention.
    drive(0, 1'b1, 1); drive(1, 1'b1, 2);
    tick(); check("par_ready", last_ready, 4'b0011);
    check("par_out_valid", bus.out_valid, 4'b1100);
    check("par_cnt2", conflict_cnt[2], 0);
    check("par_cnt3", conflict_cnt[3], 0);
    bus.in_valid = '0; tick();

    // Backpressure on port 0: one capture then stall with stable data.
    bus.out_ready = 4'b1110;
    drive(2, 1'b1, 0);
    hold_pkt = bus.in_pkt[2];
    tick(); check("bp_capture", last_ready, 4'b0100);
    drive(2, 1'b1, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_stall_ready", last_ready, '0);
      check("bp_hold_pkt", bus.out_pkt[0], hold_pkt);
    end
    bus.out_ready = '1;
    hold_pkt = bus.in_pkt[2];
    tick(); check("bp_refill", last_ready, 4'b0100);
    check("bp_refill_pkt", bus.out_pkt[0], hold_pkt);
    bus.in_valid = '0; tick();

    // Drain and refill port 1 in the same cycle without a bubble.
    drive(3, 1'b1, 3);
    tick(); check("rf_first", last_ready, 4'b1000);
    drive(3, 1'b1, 3);
    hold_pkt = bus.in_pkt[3];
    tick(); check("rf_second", last_ready, 4'b1000);
    check("rf_valid", bus.out_valid[1], 1);
    check("rf_pkt", bus.out_pkt[1], hold_pkt);
    bus.in_valid = '0; tick();

    // Table write takes effect only from the next cycle.
    cfg_we = 1'b1; cfg_node = 4'd5; cfg_port = 2'd0;
    drive(0, 1'b1, 5);
    tick(); check("cfg_old_route", bus.out_valid, 4'b0010);
    cfg_we = 1'b0;
    drive(0, 1'b1, 5);
    tick(); check("cfg_new_route", bus.out_valid, 4'b0001);
    bus.in_valid = '0; tick();

    // Reset with all outputs full, then confirm restored table and pointer.
    bus.out_ready = '0;
    for (int i = 0; i < NP; i++) drive(i, 1'b1, i);
    tick(); check("full_valid", bus.out_valid, 4'b1111);
    bus.in_valid = '0;
    reset = 1'b1;
    tick(); check("mid_rst_valid", bus.out_valid, '0);
    for (int o = 0; o < NP; o++) check($sformatf("mid_rst_cnt[%0d]", o), conflict_cnt[o], 0);
    reset = 1'b0;
    bus.out_ready = '1;
    for (int i = 0; i < NP; i++) drive(i, 1'b1, 0);
    tick(); check("post_rst_ptr", last_ready, 4'b0001);
    bus.in_valid = '0;
    drive(0, 1'b1, 5);
    tick(); check("post_rst_table", bus.out_valid, 4'b0010);
    bus.in_valid = '0; tick();

    // Random traffic; an input keeps its packet until it is taken.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!bus.in_valid[i] || last_ready[i])
          drive(i, $urandom_range(0, 2) != 0, int'($urandom_range(0, NUM_NODES - 1)));
      end
      bus.out_ready = NUM_PORTS'($urandom);
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_node = NODE_W'($urandom);
      cfg_port = PSEL_W'($urandom_range(0, NUM_PORTS - 1));
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0; bus.in_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
